register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/cpu_pkg.sv | 14 +
 rtl/reg_cell.sv | 30 +++
 rtl/register_file.sv | 84 ++++++++
 tb/tb_register_file.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared processor constants: operand width, register-index width and the
// hardwired-zero register index used by the ALU, logic units and register file.
package cpu_pkg;

    localparam int CPU_DATA_WIDTH = 16;
    localparam int CPU_ADDR_WIDTH = 3;
    localparam int CPU_REG_ZERO   = 0;

    // True when an index names the constant-zero register.
    function automatic logic is_reg_zero(input int unsigned idx);
        return (idx == CPU_REG_ZERO);
    endfunction

endpackage

// File: rtl/reg_cell.sv
// One architectural register: a W-bit flop bank with load enable and
// asynchronous active-high clear.
module reg_cell
    import cpu_pkg::*;
#(
    parameter int W = CPU_DATA_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_r;

    // Storage: async clear dominates, otherwise load on enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r <= {W{1'b0}};
        end else if (en) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/register_file.sv
// Two-read, one-write register file with hardwired-zero R0, optional
// write-to-read bypass and a committed-write counter for debug.
module register_file
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = CPU_DATA_WIDTH,
    parameter int ADDR_WIDTH = CPU_ADDR_WIDTH,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] WriteReg,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic [ADDR_WIDTH-1:0] ReadReg1,
    input  logic [ADDR_WIDTH-1:0] ReadReg2,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    output logic [7:0]            WriteCount
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(CPU_REG_ZERO);

    logic [DATA_WIDTH-1:0] regs_s [NUM_REGS];
    logic                  write_hit_s;
    logic [7:0]            count_r;
    logic [DATA_WIDTH-1:0] rd1_s;
    logic [DATA_WIDTH-1:0] rd2_s;

    assign write_hit_s = RegWrite && !is_reg_zero(32'(WriteReg));
    assign regs_s[ZERO_IDX] = {DATA_WIDTH{1'b0}};

    // Only R0 is constant; every other index gets its own cell.
    for (genvar i = 1; i < NUM_REGS; i++) begin : g_cell
        reg_cell #(.W(DATA_WIDTH)) u_cell (
            .clk (Clock),
            .rst (Reset),
            .en  (RegWrite && (WriteReg == ADDR_WIDTH'(i))),
            .d   (WriteData),
            .q   (regs_s[i])
        );
    end

    // Committed-write counter, wraps silently at 8 bits.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count_r <= 8'd0;
        end else if (write_hit_s) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    // Read port A: mux, then zero-index / reset / bypass overrides.
    always_comb begin
        rd1_s = regs_s[ReadReg1];
        if (Reset || (ReadReg1 == ZERO_IDX)) begin
            rd1_s = {DATA_WIDTH{1'b0}};
        end else if (BYPASS && write_hit_s && (ReadReg1 == WriteReg)) begin
            rd1_s = WriteData;
        end else begin
            rd1_s = regs_s[ReadReg1];
        end
    end

    // Read port B: same structure as port A.
    always_comb begin
        rd2_s = regs_s[ReadReg2];
        if (Reset || (ReadReg2 == ZERO_IDX)) begin
            rd2_s = {DATA_WIDTH{1'b0}};
        end else if (BYPASS && write_hit_s && (ReadReg2 == WriteReg)) begin
            rd2_s = WriteData;
        end else begin
            rd2_s = regs_s[ReadReg2];
        end
    end

    assign ReadData1  = rd1_s;
    assign ReadData2  = rd2_s;
    assign WriteCount = count_r;

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: a bypassing and a non-bypassing
// instance share stimulus; expectations are queued and checked at negedge.
module tb_register_file;

    logic        clk;
    logic        rst;
    logic        reg_write;
    logic [2:0]  write_reg;
    logic [15:0] write_data;
    logic [2:0]  read_reg1;
    logic [2:0]  read_reg2;
    logic [15:0] rd1_byp, rd2_byp, rd1_nob, rd2_nob;
    logic [7:0]  wc_byp, wc_nob;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          sel;
        logic [15:0] exp;
        string       name;
    } chk_t;

    chk_t sb[$];

    register_file #(.BYPASS(1'b1)) u_byp (
        .Clock(clk), .Reset(rst), .RegWrite(reg_write), .WriteReg(write_reg),
        .WriteData(write_data), .ReadReg1(read_reg1), .ReadReg2(read_reg2),
        .ReadData1(rd1_byp), .ReadData2(rd2_byp), .WriteCount(wc_byp)
    );

    register_file #(.BYPASS(1'b0)) u_nob (
        .Clock(clk), .Reset(rst), .RegWrite(reg_write), .WriteReg(write_reg),
        .WriteData(write_data), .ReadReg1(read_reg1), .ReadReg2(read_reg2),
        .ReadData1(rd1_nob), .ReadData2(rd2_nob), .WriteCount(wc_nob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] pick(input int sel);
        case (sel)
            0:       return rd1_byp;
            1:       return rd2_byp;
            2:       return {8'd0, wc_byp};
            3:       return rd1_nob;
            4:       return rd2_nob;
            5:       return {8'd0, wc_nob};
            default: return 16'hxxxx;
        endcase
    endfunction

    // Monitor: drain every expectation queued during this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            chk_t c;
            logic [15:0] act;
            c = sb.pop_front();
            act = pick(c.sel);
            checks++;
            if (act !== c.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
            end
        end
    end

    task automatic push(input int sel, input logic [15:0] exp, input string name);
        chk_t c;
        c.sel = sel;
        c.exp = exp;
        c.name = name;
        sb.push_back(c);
    endtask

    // Expectations for bypass (b) and non-bypass (n) instances.
    task automatic exp_rd1(input logic [15:0] b, input logic [15:0] n, input string name);
        push(0, b, {name, "_rd1_byp"});
        push(3, n, {name, "_rd1_nob"});
    endtask

    task automatic exp_rd2(input logic [15:0] b, input logic [15:0] n, input string name);
        push(1, b, {name, "_rd2_byp"});
        push(4, n, {name, "_rd2_nob"});
    endtask

    task automatic exp_wc(input logic [7:0] v, input string name);
        push(2, {8'd0, v}, {name, "_wc_byp"});
        push(5, {8'd0, v}, {name, "_wc_nob"});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [2:0] wr, input logic [15:0] wd,
                         input logic [2:0] r1, input logic [2:0] r2);
        reg_write  = we;
        write_reg  = wr;
        write_data = wd;
        read_reg1  = r1;
        read_reg2  = r2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 3'd0, 16'h0000, 3'd3, 3'd0);
        cyc();
        exp_rd1(16'h0000, 16'h0000, "por");
        exp_wc(8'd0, "por");

        // First edge after deassert must accept the write.
        cyc();
        rst = 1'b0;
        drive(1'b1, 3'd3, 16'h1234, 3'd1, 3'd2);
        exp_rd1(16'h0000, 16'h0000, "first_wr");
        exp_wc(8'd0, "first_wr");
        cyc();
        drive(1'b0, 3'd0, 16'h0000, 3'd3, 3'd0);
        exp_rd1(16'h1234, 16'h1234, "r3_stored");
        exp_wc(8'd1, "r3_stored");

        // Mid-cycle reset with a colliding write: immediate clear, write dropped.
        cyc();
        #2;
        rst = 1'b1;
        drive(1'b1, 3'd3, 16'h5555, 3'd3, 3'd3);
        exp_rd1(16'h0000, 16'h0000, "rst_imm");
        exp_rd2(16'h0000, 16'h0000, "rst_imm");
        exp_wc(8'd0, "rst_imm");
        cyc();
        rst = 1'b0;
        drive(1'b0, 3'd0, 16'h0000, 3'd3, 3'd0);
        exp_rd1(16'h0000, 16'h0000, "rst_wr_drop");
        exp_wc(8'd0, "rst_wr_drop");

        // Write to R0 is ignored, including by the bypass path.
        cyc();
        drive(1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0);
        exp_rd1(16'h0000, 16'h0000, "r0_wr_same");
        cyc();
        drive(1'b0, 3'd0, 16'h0000, 3'd0, 3'd0);
        exp_rd1(16'h0000, 16'h0000, "r0_after");
        exp_wc(8'd0, "r0_after");

        // Basic write/read on two registers.
        cyc();
        drive(1'b1, 3'd5, 16'hA5A5, 3'd0, 3'd0);
        cyc();
        drive(1'b1, 3'd6, 16'h0F0F, 3'd0, 3'd0);
        cyc();
        drive(1'b0, 3'd0, 16'h0000, 3'd5, 3'd6);
        exp_rd1(16'hA5A5, 16'hA5A5, "r5");
        exp_rd2(16'h0F0F, 16'h0F0F, "r6");
        exp_wc(8'd2, "basic");

        // Same-cycle bypass versus stored value.
        cyc();
        drive(1'b1, 3'd2, 16'h0001, 3'd0, 3'd0);
        cyc();
        drive(1'b1, 3'd2, 16'h00FF, 3'd2, 3'd5);
        exp_rd1(16'h00FF, 16'h0001, "bypass_pre");
        exp_rd2(16'hA5A5, 16'hA5A5, "bypass_other");
        exp_wc(8'd3, "bypass_pre");
        cyc();
        drive(1'b0, 3'd0, 16'h0000, 3'd2, 3'd0);
        exp_rd1(16'h00FF, 16'h00FF, "bypass_post");
        exp_wc(8'd4, "bypass_post");

        // Both ports on R7, then both ports bypassing into R7.
        cyc();
        drive(1'b1, 3'd7, 16'hBEEF, 3'd0, 3'd0);
        cyc();
        drive(1'b0, 3'd0, 16'h0000, 3'd7, 3'd7);
        exp_rd1(16'hBEEF, 16'hBEEF, "dual");
        exp_rd2(16'hBEEF, 16'hBEEF, "dual");
        exp_wc(8'd5, "dual");
        cyc();
        drive(1'b1, 3'd7, 16'h1111, 3'd7, 3'd7);
        exp_rd1(16'h1111, 16'hBEEF, "dual_byp");
        exp_rd2(16'h1111, 16'hBEEF, "dual_byp");
        cyc();
        drive(1'b0, 3'd0, 16'h0000, 3'd7, 3'd3);
        exp_rd1(16'h1111, 16'h1111, "dual_post");
        exp_rd2(16'h0000, 16'h0000, "r3_untouched");
        exp_wc(8'd6, "dual_post");

        // Counter wrap after 256 committed writes from reset.
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 3'((i % 7) + 1), 16'(i), 3'd0, 3'd0);
            if (i == 255) exp_wc(8'd255, "wrap_pre");
            cyc();
        end
        drive(1'b0, 3'd0, 16'h0000, 3'd4, 3'd1);
        exp_wc(8'd0, "wrap");
        exp_rd1(16'h00FF, 16'h00FF, "wrap_r4");
        exp_rd2(16'h00FC, 16'h00FC, "wrap_r1");

        cyc();
        cyc();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
